// File: rtl/vending_pkg.sv
// Shared constants for the coin/button conditioner: coin values, debouncer
// state encoding and the button index ordering.
package vending_pkg;

   localparam logic [4:0] CENTS_NICKEL  = 5'd5;
   localparam logic [4:0] CENTS_DIME    = 5'd10;
   localparam logic [4:0] CENTS_QUARTER = 5'd25;

   // Coins occupy the low indices so the coin subset is a contiguous slice.
   localparam int unsigned BTN_NICKEL  = 0;
   localparam int unsigned BTN_DIME    = 1;
   localparam int unsigned BTN_QUARTER = 2;
   localparam int unsigned BTN_BUY     = 3;
   localparam int unsigned BTN_CANCEL  = 4;
   localparam int unsigned NUM_COINS   = 3;
   localparam int unsigned NUM_BTNS    = 5;

   typedef enum logic [1:0] {
      DB_IDLE      = 2'd0,
      DB_ARMING    = 2'd1,
      DB_PRESSED   = 2'd2,
      DB_RELEASING = 2'd3
   } db_state_t;

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer plus debounce FSM for one push-button; emits a
// single-cycle press strobe when a press is accepted.
module button_debouncer
   import vending_pkg::*;
#(
   parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic press
);

   logic        sync_meta, sync_q;
   db_state_t   state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic        last_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_meta <= 1'b0;
         sync_q    <= 1'b0;
         state_q   <= DB_IDLE;
         cnt_q     <= '0;
      end else begin
         sync_meta <= raw;
         sync_q    <= sync_meta;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
      end
   end

   // Counter is 0 on entry to IDLE/PRESSED, so a single-cycle debounce
   // completes directly from those states.
   assign last_cnt = (cnt_q == DEBOUNCE_CYCLES - 16'd1);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      press   = 1'b0;
      unique case (state_q)
         DB_IDLE: begin
            if (sync_q) begin
               if (last_cnt) begin
                  state_d = DB_PRESSED;
                  cnt_d   = '0;
                  press   = 1'b1;
               end else begin
                  state_d = DB_ARMING;
                  cnt_d   = cnt_q + 16'd1;
               end
            end
         end
         DB_ARMING: begin
            if (!sync_q) begin
               state_d = DB_IDLE;
               cnt_d   = '0;
            end else if (last_cnt) begin
               state_d = DB_PRESSED;
               cnt_d   = '0;
               press   = 1'b1;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         DB_PRESSED: begin
            if (!sync_q) begin
               if (last_cnt) begin
                  state_d = DB_IDLE;
                  cnt_d   = '0;
               end else begin
                  state_d = DB_RELEASING;
                  cnt_d   = cnt_q + 16'd1;
               end
            end
         end
         DB_RELEASING: begin
            if (sync_q) begin
               state_d = DB_PRESSED;
               cnt_d   = '0;
            end else if (last_cnt) begin
               state_d = DB_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: begin
            state_d = DB_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

endmodule

// File: rtl/coin_button_conditioner.sv
// Debounces coin and command buttons, queues coins behind a valid/ready
// handshake and defers commands until no coin is pending.
// Optional coin_total statistics output: define COIN_CONDITIONER_STATS_EN.
module coin_button_conditioner
   import vending_pkg::*;
#(
   parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       nickel,
   input  logic       dime,
   input  logic       quarter,
   input  logic       buy,
   input  logic       cancel,
   output logic       coin_valid,
   output logic [4:0] coin_value,
   input  logic       coin_ready,
   output logic       buy_pulse,
   output logic       cancel_pulse,
   output logic       coin_overrun
`ifdef COIN_CONDITIONER_STATS_EN
   ,
   output logic [15:0] coin_total
`endif
);

   logic [NUM_BTNS-1:0]  raw_btn, press_ev;
   logic [NUM_COINS-1:0] coin_pend, coin_sel, coin_clr, coin_new;
   logic                 buy_pend, cancel_pend;
   logic                 coin_hs, cmd_idle;

   assign raw_btn[BTN_NICKEL]  = nickel;
   assign raw_btn[BTN_DIME]    = dime;
   assign raw_btn[BTN_QUARTER] = quarter;
   assign raw_btn[BTN_BUY]     = buy;
   assign raw_btn[BTN_CANCEL]  = cancel;

   for (genvar g = 0; g < NUM_BTNS; g++) begin : g_db
      button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .clk   (clk),
         .rst_n (rst_n),
         .raw   (raw_btn[g]),
         .press (press_ev[g])
      );
   end

   always_comb begin
      coin_sel   = '0;
      coin_value = '0;
      if (coin_pend[BTN_QUARTER]) begin
         coin_sel[BTN_QUARTER] = 1'b1;
         coin_value            = CENTS_QUARTER;
      end else if (coin_pend[BTN_DIME]) begin
         coin_sel[BTN_DIME] = 1'b1;
         coin_value         = CENTS_DIME;
      end else if (coin_pend[BTN_NICKEL]) begin
         coin_sel[BTN_NICKEL] = 1'b1;
         coin_value           = CENTS_NICKEL;
      end
   end

   assign coin_valid   = |coin_pend;
   assign coin_hs      = coin_valid & coin_ready;
   assign coin_clr     = coin_sel & {NUM_COINS{coin_hs}};
   assign coin_new     = press_ev[NUM_COINS-1:0];
   // A press coinciding with its own handshake clear is not an overrun.
   assign coin_overrun = |(coin_new & coin_pend & ~coin_clr);

   assign cmd_idle     = ~coin_valid;
   assign cancel_pulse = cancel_pend & cmd_idle;
   assign buy_pulse    = buy_pend & ~cancel_pend & cmd_idle;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         coin_pend   <= '0;
         buy_pend    <= 1'b0;
         cancel_pend <= 1'b0;
      end else begin
         coin_pend   <= (coin_pend & ~coin_clr) | coin_new;
         // When idle both flags retire together; cancel wins over buy.
         buy_pend    <= (buy_pend & ~cmd_idle) | press_ev[BTN_BUY];
         cancel_pend <= (cancel_pend & ~cmd_idle) | press_ev[BTN_CANCEL];
      end
   end

`ifdef COIN_CONDITIONER_STATS_EN
   logic [16:0] total_sum;

   assign total_sum = {1'b0, coin_total} + {12'd0, coin_value};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         coin_total <= '0;
      end else if (cancel_pulse) begin
         coin_total <= '0;
      end else if (coin_hs) begin
         coin_total <= total_sum[16] ? '1 : total_sum[15:0];
      end
   end
`endif

endmodule

// File: doc/coin_button_conditioner.md
COIN_BUTTON_CONDITIONER -- requirements
Module: coin_button_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16'd50000, the consecutive stable synchronized cycles required to accept a level change (minimum 1).
REQ-002 SHALL have port clk, input, 1, the single clock.
REQ-003 SHALL have port rst_n, input, 1, the reset: asynchronous, active-low.
REQ-004 SHALL have ports nickel, dime, quarter, buy, cancel, each input, 1, a raw asynchronous push-button (high = pressed).
REQ-005 SHALL have port coin_valid, output, 1, meaning a coin event is presented.
REQ-006 SHALL have port coin_value, output, 5, the presented coin value in cents (5, 10 or 25; 0 when coin_valid is 0).
REQ-007 SHALL have port coin_ready, input, 1, the downstream acceptance of the presented coin.
REQ-008 SHALL have ports buy_pulse and cancel_pulse, each output, 1, a one-cycle command strobe.
REQ-009 SHALL have port coin_overrun, output, 1, a one-cycle strobe marking a dropped coin press.

Function
REQ-010 SHALL synchronize each raw input through 2 flops before any other use.
REQ-011 SHALL debounce each synchronized input with its own FSM (IDLE, ARMING, PRESSED, RELEASING) and its own counter.
- IDLE -> ARMING when the synchronized input goes high.
- ARMING -> PRESSED after DEBOUNCE_CYCLES consecutive high cycles; one press event is generated on this transition.
- ARMING -> IDLE on any low cycle; the counter clears.
- PRESSED -> RELEASING on low; RELEASING -> IDLE after DEBOUNCE_CYCLES consecutive low cycles.
- RELEASING -> PRESSED on any high cycle, with no new event.
REQ-012 SHALL make the press event latency exactly 2+DEBOUNCE_CYCLES clock edges from the first edge that samples the raw input high.
REQ-013 SHALL hold a pending flag per coin; a coin press event sets its flag.
REQ-014 SHALL drive coin_valid as the OR of the pending flags, with coin_value chosen by priority quarter > dime > nickel.
REQ-015 SHALL clear the presented coin's flag on a clock edge where coin_valid and coin_ready are both 1.
- coin_valid and coin_value stay stable until that handshake.
REQ-016 SHALL let a press take effect when it coincides with the handshake clear of the same coin: the flag stays set.
REQ-017 SHALL drop a coin press whose flag is already set and not being cleared, and pulse coin_overrun for one cycle.
REQ-018 SHALL defer buy and cancel press events into a buy_pend and a cancel_pend flag.
- Each flag issues its pulse in the first cycle in which all coin flags are 0, then clears.
- Coins are therefore always delivered before commands.
REQ-019 SHALL, when buy_pend and cancel_pend are both set, issue only cancel_pulse and discard buy_pend.
REQ-020 SHALL never assert buy_pulse and cancel_pulse in the same cycle, nor either pulse for more than one cycle per press.

Reset
REQ-021 SHALL, while rst_n is 0, put every debouncer in IDLE, clear all counters, synchronizers and pending flags, and drive every output to 0.
REQ-022 SHALL, on a reset mid-operation (debounce in progress or coin pending), discard the work in progress.
- A button still held at reset release SHALL produce a press event after the full latency of REQ-012.

Configuration
REQ-023 SHALL, with macro COIN_CONDITIONER_STATS_EN defined, add output coin_total[15:0].
- coin_total SHALL add coin_value on each coin handshake, saturate at 16'hFFFF, and clear on reset and on cancel_pulse.
- Without the macro, the port and its logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-024 SHALL place the coin value constants (5, 10, 25), the debouncer state encoding and the coin index ordering in shared package vending_pkg.
REQ-025 SHALL implement the synchronizer plus debounce FSM once, as sub-module button_debouncer, instantiated 5 times.

Verification (DEBOUNCE_CYCLES=4)
REQ-026 SHALL cover a clean press: hold dime high from edge 1 -> press event after edge 6, coin_valid=1 with coin_value=10 until coin_ready, then 0.
REQ-027 SHALL cover bounce: nickel toggled high/low every 2 cycles for 20 cycles, then held -> exactly one coin event, and none during the toggling.
REQ-028 SHALL cover simultaneous coins: nickel, dime and quarter pressed together, coin_ready=1 -> values 25, 10, 5 on consecutive cycles.
REQ-029 SHALL cover command ordering: quarter and buy pressed together, coin_ready held 0 for 3 cycles -> no buy_pulse until the quarter is accepted, then buy_pulse exactly one cycle later.
REQ-030 SHALL cover overrun: nickel pressed, released and pressed again while coin_ready=0 -> one coin_overrun pulse, a single nickel delivered.
REQ-031 SHALL cover reset mid-debounce: rst_n=0 at edge 4 of a held quarter press -> all outputs 0, and after release the press event arrives 6 edges later.
